btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 150 +++++++++++++++
 tb/tb_btn_conditioner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel 2-flop sync, debounce FSM, press/release pulses.
// Optional auto-repeat on held buttons when BTN_AUTOREPEAT_EN is defined.
`default_nettype none

module btn_conditioner #(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int              CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HELD      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

`ifdef BTN_AUTOREPEAT_EN
  localparam int            RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW       = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] R_LAST   = RW'(RMAX - 1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD - 1);
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]    sync_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          s;

    assign s     = sync_q[1];
    assign cnt_d = (cnt_q == DB_LAST) ? cnt_q : cnt_q + 1'b1;

`ifdef BTN_AUTOREPEAT_EN
    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;
    logic          rphase_q;

    assign rcnt_d = (rcnt_q == R_LAST) ? rcnt_q : rcnt_q + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q    <= 2'b00;
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rcnt_q    <= '0;
        rphase_q  <= 1'b0;
`endif
      end else begin
        sync_q    <= {sync_q[0], btn_raw[i]};
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (s) begin
              state_q <= WAIT_HIGH;
              cnt_q   <= '0;
            end
          end
          WAIT_HIGH: begin
            if (!s) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_d == DB_LAST) begin
              state_q <= HELD;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              rcnt_q   <= '0;
              rphase_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_d;
            end
          end
          HELD: begin
            if (!s) begin
              state_q <= WAIT_LOW;
              cnt_q   <= '0;
`ifdef BTN_AUTOREPEAT_EN
              rcnt_q   <= '0;
              rphase_q <= 1'b0;
`endif
            end
`ifdef BTN_AUTOREPEAT_EN
            // First repeat after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD.
            else if (rcnt_q == (rphase_q ? R_PERIOD : R_DELAY)) begin
              press_q  <= 1'b1;
              rcnt_q   <= '0;
              rphase_q <= 1'b1;
            end else begin
              rcnt_q <= rcnt_d;
            end
`endif
          end
          WAIT_LOW: begin
            if (s) begin
              state_q <= HELD;
              cnt_q   <= '0;
`ifdef BTN_AUTOREPEAT_EN
              rcnt_q   <= '0;
              rphase_q <= 1'b0;
`endif
            end else if (cnt_d == DB_LAST) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
`default_nettype none

module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  int total = 0;
  int bad   = 0;

  btn_conditioner #(
    .N_BTN        (4),
    .DB_CYCLES    (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk3(input string tag, input logic [3:0] ep, input logic [3:0] er,
                      input logic [3:0] el);
    chk({tag, ".press"},   btn_press,   ep);
    chk({tag, ".release"}, btn_release, er);
    chk({tag, ".level"},   btn_level,   el);
  endtask

  initial begin
    logic [3:0] ep;
    logic [3:0] er;
    logic [3:0] el;

    rst     = 1'b0;
    btn_raw = 4'b0000;
    #2;
    chk3("reset", 4'b0000, 4'b0000, 4'b0000);
    tick();
    tick();
    chk3("reset_hold", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk3("idle", 4'b0000, 4'b0000, 4'b0000);
    end

    // Clean press on channel 0
    btn_raw = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      ep = (k == 6) ? 4'b0001 : 4'b0000;
      el = (k >= 6) ? 4'b0001 : 4'b0000;
      chk3("clean_press", ep, 4'b0000, el);
    end
    btn_raw = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      er = (k == 6) ? 4'b0001 : 4'b0000;
      el = (k < 6) ? 4'b0001 : 4'b0000;
      chk3("clean_release", 4'b0000, er, el);
    end

    // Bounce on channel 1
    for (int b = 0; b < 4; b++) begin
      btn_raw = (b % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
      chk3("bouncing", 4'b0000, 4'b0000, 4'b0000);
    end
    btn_raw = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      tick();
      ep = (k == 6) ? 4'b0010 : 4'b0000;
      el = (k >= 6) ? 4'b0010 : 4'b0000;
      chk3("bounce_press", ep, 4'b0000, el);
    end
    btn_raw = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      er = (k == 6) ? 4'b0010 : 4'b0000;
      el = (k < 6) ? 4'b0010 : 4'b0000;
      chk3("bounce_release", 4'b0000, er, el);
    end

    // Release with glitch on channel 2
    btn_raw = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ep = (k == 6) ? 4'b0100 : 4'b0000;
      el = (k >= 6) ? 4'b0100 : 4'b0000;
      chk3("ch2_press", ep, 4'b0000, el);
    end
    btn_raw = 4'b0000;
    tick();
    chk3("glitch_low1", 4'b0000, 4'b0000, 4'b0100);
    tick();
    chk3("glitch_low2", 4'b0000, 4'b0000, 4'b0100);
    btn_raw = 4'b0100;
    tick();
    chk3("glitch_high", 4'b0000, 4'b0000, 4'b0100);
    btn_raw = 4'b0000;
    for (int k = 1; k <= 9; k++) begin
      tick();
      er = (k == 6) ? 4'b0100 : 4'b0000;
      el = (k < 6) ? 4'b0100 : 4'b0000;
      chk3("glitch_release", 4'b0000, er, el);
    end

    // All channels rise together
    btn_raw = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ep = (k == 6) ? 4'b1111 : 4'b0000;
      el = (k >= 6) ? 4'b1111 : 4'b0000;
      chk3("simul_press", ep, 4'b0000, el);
    end

    // Release all but channel 3, then reset while it is HELD
    btn_raw = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      er = (k == 6) ? 4'b0111 : 4'b0000;
      el = (k < 6) ? 4'b1111 : 4'b1000;
      chk3("partial_release", 4'b0000, er, el);
    end
    #2;
    rst = 1'b0;
    #1;
    chk3("reset_async", 4'b0000, 4'b0000, 4'b0000);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk3("reset_no_release", 4'b0000, 4'b0000, 4'b0000);
    end
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ep = (k == 6) ? 4'b1000 : 4'b0000;
      el = (k >= 6) ? 4'b1000 : 4'b0000;
      chk3("post_reset_press", ep, 4'b0000, el);
    end
    btn_raw = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      er = (k == 6) ? 4'b1000 : 4'b0000;
      el = (k < 6) ? 4'b1000 : 4'b0000;
      chk3("ch3_release", 4'b0000, er, el);
    end

    // Long hold on channel 0: repeat pulses only with the feature built in
    btn_raw = 4'b0001;
    for (int k = 1; k <= 40; k++) begin
      tick();
`ifdef BTN_AUTOREPEAT_EN
      ep = (k == 6 || (k >= 16 && k <= 34 && (k - 16) % 3 == 0)) ? 4'b0001 : 4'b0000;
`else
      ep = (k == 6) ? 4'b0001 : 4'b0000;
`endif
      er = (k == 39) ? 4'b0001 : 4'b0000;
      el = (k >= 6 && k < 39) ? 4'b0001 : 4'b0000;
      chk3("long_hold", ep, er, el);
      if (k == 33) btn_raw = 4'b0000;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
